// File: rtl/flash_writer_pkg.sv
// Shared definitions for the flash write path: command codes, status bits,
// state encodings and the latched request payload.
package flash_writer_pkg;

  localparam int unsigned ADDR_W  = 22;
  localparam int unsigned FADDR_W = 23;
  localparam int unsigned DATA_W  = 16;
  localparam int unsigned SR_W    = 8;
  localparam int unsigned POLL_W  = 21;
  localparam int unsigned CNT_W   = 8;

  localparam logic [DATA_W-1:0] FLASH_CMD_PROGRAM = 16'h0040;
  localparam logic [DATA_W-1:0] FLASH_CMD_ERASE   = 16'h0020;
  localparam logic [DATA_W-1:0] FLASH_CMD_CONFIRM = 16'h00D0;
  localparam logic [DATA_W-1:0] FLASH_CMD_CLRSR   = 16'h0050;
  localparam logic [DATA_W-1:0] FLASH_CMD_READ    = 16'h00FF;

  localparam int unsigned SR_READY     = 7;
  localparam int unsigned SR_ERASE_ERR = 5;
  localparam int unsigned SR_PROG_ERR  = 4;
  localparam int unsigned SR_VPEN_ERR  = 3;
  localparam int unsigned SR_LOCK_ERR  = 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ARG,
    ST_POLL,
    ST_CLR,
    ST_RESTORE,
    ST_DONE
  } wr_state_e;

  typedef enum logic [1:0] {
    PH_IDLE,
    PH_SETUP,
    PH_LOW,
    PH_TAIL
  } bus_phase_e;

  typedef struct packed {
    logic              erase;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } flash_req_t;

  function automatic logic sr_error(input logic [SR_W-1:0] sr);
    return sr[SR_ERASE_ERR] | sr[SR_PROG_ERR] | sr[SR_VPEN_ERR] | sr[SR_LOCK_ERR];
  endfunction

endpackage

// File: rtl/flash_bus_cycle.sv
// One flash bus read or write cycle with all pin timing. A new start may be
// issued during the final (hold/recovery) clock for back-to-back cycles.
module flash_bus_cycle
  import flash_writer_pkg::*;
#(
  parameter int unsigned WE_CYCLES = 2,
  parameter int unsigned RD_CYCLES = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               rd_wr,
  input  logic [FADDR_W-1:0] addr,
  input  logic [DATA_W-1:0]  wdata,
  input  logic [SR_W-1:0]    data_in,
  output logic               ack,
  output logic [SR_W-1:0]    rdata,
  output logic [FADDR_W-1:0] flash_addr,
  output logic [DATA_W-1:0]  data_out,
  output logic               data_oe,
  output logic               flash_ce,
  output logic               flash_oe,
  output logic               flash_we
);

  bus_phase_e         phase_q, phase_n;
  logic [CNT_W-1:0]   cnt_q, cnt_n, lim;
  logic               rd_q, rd_n;
  logic [FADDR_W-1:0] addr_n;
  logic [DATA_W-1:0]  wdata_n;
  logic               ce_n, oe_n, we_n, data_oe_n, ack_n, sample;

  // Phase sequencing; pin levels are derived from the upcoming phase so they
  // are registered and line up exactly with it.
  always_comb begin
    phase_n = phase_q;
    cnt_n   = cnt_q;
    rd_n    = rd_q;
    addr_n  = flash_addr;
    wdata_n = data_out;
    lim     = rd_q ? CNT_W'(RD_CYCLES - 1) : CNT_W'(WE_CYCLES - 1);
    sample  = 1'b0;

    unique case (phase_q)
      PH_IDLE:  phase_n = PH_IDLE;
      PH_SETUP: begin
        phase_n = PH_LOW;
        cnt_n   = '0;
      end
      PH_LOW: begin
        if (cnt_q == lim) begin
          phase_n = PH_TAIL;
          sample  = rd_q;
        end else begin
          cnt_n = cnt_q + 1'b1;
        end
      end
      PH_TAIL:  phase_n = PH_IDLE;
      default:  phase_n = PH_IDLE;
    endcase

    if (start && (phase_q == PH_IDLE || phase_q == PH_TAIL)) begin
      phase_n = PH_SETUP;
      rd_n    = rd_wr;
      addr_n  = addr;
      wdata_n = wdata;
    end

    ce_n      = !(phase_n == PH_SETUP || phase_n == PH_LOW || (phase_n == PH_TAIL && !rd_n));
    we_n      = !(phase_n == PH_LOW && !rd_n);
    oe_n      = !(phase_n == PH_LOW && rd_n);
    data_oe_n = !rd_n && (phase_n != PH_IDLE);
    ack_n     = (phase_n == PH_TAIL);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q    <= PH_IDLE;
      cnt_q      <= '0;
      rd_q       <= 1'b0;
      flash_addr <= '0;
      data_out   <= '0;
      data_oe    <= 1'b0;
      flash_ce   <= 1'b1;
      flash_oe   <= 1'b1;
      flash_we   <= 1'b1;
      ack        <= 1'b0;
      rdata      <= '0;
    end else begin
      phase_q    <= phase_n;
      cnt_q      <= cnt_n;
      rd_q       <= rd_n;
      flash_addr <= addr_n;
      data_out   <= wdata_n;
      data_oe    <= data_oe_n;
      flash_ce   <= ce_n;
      flash_oe   <= oe_n;
      flash_we   <= we_n;
      ack        <= ack_n;
      if (sample) rdata <= data_in;
    end
  end

endmodule

// File: rtl/flash_writer.sv
// Programs single words and erases blocks in a CFI/Intel-command-set flash,
// sequencing command, confirm, status polling, error clear and read-array restore.
module flash_writer
  import flash_writer_pkg::*;
#(
  parameter int unsigned WE_CYCLES  = 2,
  parameter int unsigned RD_CYCLES  = 2,
  parameter int unsigned POLL_LIMIT = 1048576
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cmd_valid,
  input  logic               cmd_erase,
  input  logic [ADDR_W-1:0]  cmd_addr,
  input  logic [DATA_W-1:0]  cmd_data,
  output logic               cmd_ready,
  output logic               busy,
  output logic               done,
  output logic               error,
  output logic [SR_W-1:0]    status_out,
  output logic [FADDR_W-1:0] flash_addr,
  inout  wire  [DATA_W-1:0]  flash_data,
  output logic               flash_byte,
  output logic               flash_vpen,
  output logic               flash_ce,
  output logic               flash_oe,
  output logic               flash_we,
  output logic               flash_rp
);

  wr_state_e         state_q, state_n;
  flash_req_t        req_q, req_n;
  logic [POLL_W-1:0] poll_q, poll_n, poll_inc;
  logic              error_n;
  logic [SR_W-1:0]   status_n;

  logic              bus_start_c, bus_rd_c, bus_ack;
  logic [ADDR_W-1:0] bus_addr_c;
  logic [DATA_W-1:0] bus_wdata_c, bus_dout;
  logic [SR_W-1:0]   bus_rdata;
  logic              bus_doe;

  assign flash_byte = 1'b1;
  assign flash_vpen = 1'b1;
  assign flash_data = bus_doe ? bus_dout : {DATA_W{1'bz}};

  // Each state owns one bus cycle; the next cycle is launched on its ack.
  always_comb begin
    state_n     = state_q;
    req_n       = req_q;
    poll_n      = poll_q;
    error_n     = error;
    status_n    = status_out;
    bus_start_c = 1'b0;
    bus_rd_c    = 1'b0;
    bus_addr_c  = req_q.addr;
    bus_wdata_c = FLASH_CMD_READ;
    poll_inc    = (poll_q == '1) ? poll_q : poll_q + 1'b1;

    unique case (state_q)
      ST_IDLE: begin
        if (cmd_valid && cmd_ready) begin
          req_n.erase = cmd_erase;
          req_n.addr  = cmd_addr;
          req_n.data  = cmd_data;
          error_n     = 1'b0;
          poll_n      = '0;
          bus_start_c = 1'b1;
          bus_addr_c  = cmd_addr;
          bus_wdata_c = cmd_erase ? FLASH_CMD_ERASE : FLASH_CMD_PROGRAM;
          state_n     = ST_CMD;
        end
      end
      ST_CMD: begin
        if (bus_ack) begin
          bus_start_c = 1'b1;
          bus_wdata_c = req_q.erase ? FLASH_CMD_CONFIRM : req_q.data;
          state_n     = ST_ARG;
        end
      end
      ST_ARG: begin
        if (bus_ack) begin
          bus_start_c = 1'b1;
          bus_rd_c    = 1'b1;
          state_n     = ST_POLL;
        end
      end
      ST_POLL: begin
        if (bus_ack) begin
          status_n    = bus_rdata;
          poll_n      = poll_inc;
          bus_start_c = 1'b1;
          if (bus_rdata[SR_READY] && !sr_error(bus_rdata)) begin
            state_n = ST_RESTORE;
          end else if (bus_rdata[SR_READY] || poll_inc >= POLL_W'(POLL_LIMIT)) begin
            bus_wdata_c = FLASH_CMD_CLRSR;
            error_n     = 1'b1;
            state_n     = ST_CLR;
          end else begin
            bus_rd_c = 1'b1;
          end
        end
      end
      ST_CLR: begin
        if (bus_ack) begin
          bus_start_c = 1'b1;
          state_n     = ST_RESTORE;
        end
      end
      ST_RESTORE: begin
        if (bus_ack) state_n = ST_DONE;
      end
      ST_DONE: state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      req_q      <= '0;
      poll_q     <= '0;
      error      <= 1'b0;
      status_out <= '0;
      cmd_ready  <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      flash_rp   <= 1'b0;
    end else begin
      state_q    <= state_n;
      req_q      <= req_n;
      poll_q     <= poll_n;
      error      <= error_n;
      status_out <= status_n;
      cmd_ready  <= (state_n == ST_IDLE);
      busy       <= (state_n != ST_IDLE) && (state_n != ST_DONE);
      done       <= (state_n == ST_DONE);
      flash_rp   <= 1'b1;
    end
  end

  flash_bus_cycle #(
    .WE_CYCLES (WE_CYCLES),
    .RD_CYCLES (RD_CYCLES)
  ) u_bus (
    .clk        (clk),
    .rst        (rst),
    .start      (bus_start_c),
    .rd_wr      (bus_rd_c),
    .addr       ({bus_addr_c, 1'b0}),
    .wdata      (bus_wdata_c),
    .data_in    (flash_data[SR_W-1:0]),
    .ack        (bus_ack),
    .rdata      (bus_rdata),
    .flash_addr (flash_addr),
    .data_out   (bus_dout),
    .data_oe    (bus_doe),
    .flash_ce   (flash_ce),
    .flash_oe   (flash_oe),
    .flash_we   (flash_we)
  );

endmodule

// File: tb/tb_flash_writer.sv
// Bench for flash_writer: a status-register flash model, a bus monitor and
// directed table vectors plus randomized operations against a reference model.
module tb_flash_writer;

  localparam int POLL_LIM = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_erase = 1'b0;
  logic [21:0] cmd_addr = '0;
  logic [15:0] cmd_data = '0;
  logic        cmd_ready, busy, done, error;
  logic [7:0]  status_out;
  logic [22:0] flash_addr;
  wire  [15:0] flash_data;
  logic        flash_byte, flash_vpen, flash_ce, flash_oe, flash_we, flash_rp;

  int n_pass = 0;
  int n_total = 0;

  flash_writer #(.WE_CYCLES(2), .RD_CYCLES(2), .POLL_LIMIT(POLL_LIM)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_erase(cmd_erase),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data), .cmd_ready(cmd_ready),
    .busy(busy), .done(done), .error(error), .status_out(status_out),
    .flash_addr(flash_addr), .flash_data(flash_data), .flash_byte(flash_byte),
    .flash_vpen(flash_vpen), .flash_ce(flash_ce), .flash_oe(flash_oe),
    .flash_we(flash_we), .flash_rp(flash_rp)
  );

  always #5 clk = ~clk;

  // Flash model: busy status until n_ready reads of this operation, then final status.
  logic [7:0] busy_sr = 8'h00;
  logic [7:0] final_sr = 8'h80;
  int         n_ready = 0;
  int         rd_base = 0;
  int         rd_count = 0;
  logic [7:0] sr_cur;
  assign sr_cur = ((rd_count - rd_base) >= n_ready) ? final_sr : busy_sr;
  assign flash_data = (!flash_ce && !flash_oe) ? {8'h00, sr_cur} : 16'hzzzz;

  // Bus monitor: a write is logged on we rising, a read on oe rising.
  logic        prev_we = 1'b1;
  logic        prev_oe = 1'b1;
  logic [22:0] wr_addr_q[$];
  logic [15:0] wr_data_q[$];
  logic [22:0] rd_addr_q[$];
  always @(negedge clk) begin
    if (!prev_we && flash_we) begin
      wr_addr_q.push_back(flash_addr);
      wr_data_q.push_back(flash_data);
    end
    if (!prev_oe && flash_oe) begin
      rd_addr_q.push_back(flash_addr);
      rd_count <= rd_count + 1;
    end
    prev_we <= flash_we;
    prev_oe <= flash_oe;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  typedef struct {
    bit          erase;
    logic [21:0] addr;
    logic [15:0] data;
    logic [7:0]  busy_sr;
    logic [7:0]  final_sr;
    int          n_ready;
    bit          exp_err;
    logic [7:0]  exp_status;
    int          exp_lat;
    int          exp_reads;
  } vec_t;

  function automatic vec_t mk(bit e, logic [21:0] a, logic [15:0] d, logic [7:0] bs,
                              logic [7:0] fs, int nr, bit ee, logic [7:0] es, int el, int er);
    vec_t v;
    v.erase = e; v.addr = a; v.data = d; v.busy_sr = bs; v.final_sr = fs; v.n_ready = nr;
    v.exp_err = ee; v.exp_status = es; v.exp_lat = el; v.exp_reads = er;
    return v;
  endfunction

  // Reference model: the device answers busy until ready or the poll budget runs out.
  function automatic vec_t model(bit e, logic [21:0] a, logic [15:0] d,
                                 logic [7:0] bs, logic [7:0] fs, int nr);
    vec_t v;
    v = mk(e, a, d, bs, fs, nr, 1'b0, 8'h00, 0, 0);
    if (nr + 1 <= POLL_LIM) begin
      v.exp_reads  = nr + 1;
      v.exp_status = fs;
      v.exp_err    = (fs & 8'h3A) != 8'h00;
    end else begin
      v.exp_reads  = POLL_LIM;
      v.exp_status = bs;
      v.exp_err    = 1'b1;
    end
    v.exp_lat = 4 + 4 + 4 * v.exp_reads + (v.exp_err ? 4 : 0) + 4;
    return v;
  endfunction

  task automatic run_op(input vec_t v, input bit poke);
    int wb, rb, cyc, nbad, nexp;
    bit got_done, ready_bad;
    logic [15:0] exp_wr[4];
    logic [22:0] fa;
    fa = {v.addr, 1'b0};
    for (int i = 0; i < 100 && !cmd_ready; i++) @(posedge clk);
    @(negedge clk);
    busy_sr = v.busy_sr; final_sr = v.final_sr; n_ready = v.n_ready; rd_base = rd_count;
    wb = wr_addr_q.size(); rb = rd_addr_q.size();
    cmd_valid = 1'b1; cmd_erase = v.erase; cmd_addr = v.addr; cmd_data = v.data;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    check("accept_busy_ready_err", {29'd0, busy, cmd_ready, error}, 32'b100);
    got_done = 1'b0; ready_bad = 1'b0; cyc = 0;
    for (int i = 1; i <= 2000; i++) begin
      @(posedge clk); #1;
      cyc = i;
      if (poke && i == 5) begin
        cmd_valid = 1'b1; cmd_erase = ~v.erase; cmd_addr = v.addr ^ 22'h2AAAA; cmd_data = ~v.data;
      end
      if (poke && i == 8) cmd_valid = 1'b0;
      if (done) begin got_done = 1'b1; break; end
      if (cmd_ready) ready_bad = 1'b1;
    end
    cmd_valid = 1'b0;
    if (!got_done) begin
      check("done_timeout", 32'(got_done), 32'd1);
      return;
    end
    check("latency", 32'(cyc), 32'(v.exp_lat));
    check("error", 32'(error), 32'(v.exp_err));
    check("status_out", 32'(status_out), 32'(v.exp_status));
    check("ready_busy_at_done", {30'd0, cmd_ready | ready_bad, busy}, 32'd0);
    @(posedge clk); #1;
    check("ready_after_done", {30'd0, cmd_ready, done}, 32'b10);
    exp_wr[0] = v.erase ? 16'h0020 : 16'h0040;
    exp_wr[1] = v.erase ? 16'h00D0 : v.data;
    exp_wr[2] = v.exp_err ? 16'h0050 : 16'h00FF;
    exp_wr[3] = 16'h00FF;
    nexp = v.exp_err ? 4 : 3;
    if (poke) repeat (12) @(posedge clk);
    #1;
    check("wr_count", 32'(wr_addr_q.size() - wb), 32'(nexp));
    check("rd_count", 32'(rd_addr_q.size() - rb), 32'(v.exp_reads));
    nbad = 0;
    for (int i = 0; i < nexp && wb + i < wr_addr_q.size(); i++)
      if (wr_data_q[wb + i] !== exp_wr[i] || wr_addr_q[wb + i] !== fa) nbad++;
    for (int i = rb; i < rd_addr_q.size(); i++)
      if (rd_addr_q[i] !== fa) nbad++;
    check("bus_contents", 32'(nbad), 32'd0);
  endtask

  vec_t vecs[8];
  vec_t rv;

  initial begin
    vecs[0] = mk(1'b0, 22'h000010, 16'hBEEF, 8'h00, 8'h80, 2,   1'b0, 8'h80, 24, 3);
    vecs[1] = mk(1'b1, 22'h010000, 16'h1234, 8'h00, 8'h80, 4,   1'b0, 8'h80, 32, 5);
    vecs[2] = mk(1'b0, 22'h000123, 16'h5A5A, 8'h00, 8'h90, 0,   1'b1, 8'h90, 20, 1);
    vecs[3] = mk(1'b0, 22'h3FFFFF, 16'h0001, 8'h00, 8'h80, 100, 1'b1, 8'h00, 48, 8);
    vecs[4] = mk(1'b1, 22'h200000, 16'h0000, 8'h00, 8'hA0, 1,   1'b1, 8'hA0, 24, 2);
    vecs[5] = mk(1'b0, 22'h0ABCDE, 16'hFFFF, 8'h00, 8'h80, 7,   1'b0, 8'h80, 44, 8);
    vecs[6] = mk(1'b0, 22'h000001, 16'h8000, 8'h00, 8'h82, 0,   1'b1, 8'h82, 20, 1);
    vecs[7] = mk(1'b0, 22'h155555, 16'hC3C3, 8'h00, 8'h84, 0,   1'b0, 8'h84, 16, 1);

    // Reset state, with a simultaneous request that must be dropped.
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs",
          {20'd0, cmd_ready, busy, done, error, flash_ce, flash_oe, flash_we, flash_rp, flash_byte, flash_vpen, 2'b00},
          {20'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 2'b00});
    check("reset_status", 32'(status_out), 32'd0);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_addr = 22'h000777; cmd_data = 16'h7777;
    @(negedge clk);
    rst = 1'b0; cmd_valid = 1'b0;
    @(posedge clk); #1;
    check("rp_release_no_accept", {28'd0, flash_rp, busy, cmd_ready, flash_ce}, 32'b1011);
    repeat (6) @(posedge clk);
    #1;
    check("no_bus_after_rst_valid", 32'(wr_addr_q.size() + rd_addr_q.size()), 32'd0);

    for (int i = 0; i < 8; i++) run_op(vecs[i], 1'b0);

    // Request pulsed while busy is ignored and not queued.
    run_op(model(1'b0, 22'h001234, 16'h4321, 8'h00, 8'h80, 3), 1'b1);

    // Reset during polling aborts the operation without a done pulse.
    @(negedge clk);
    busy_sr = 8'h00; final_sr = 8'h80; n_ready = 100; rd_base = rd_count;
    cmd_valid = 1'b1; cmd_erase = 1'b0; cmd_addr = 22'h000040; cmd_data = 16'hAAAA;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    check("rst_mid_pins", {27'd0, flash_ce, flash_oe, flash_we, flash_rp, done}, 32'b11100);
    begin
      bit saw_done;
      saw_done = done;
      repeat (2) begin @(posedge clk); #1; saw_done |= done | busy; end
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk); #1;
      check("rst_mid_release", {29'd0, saw_done, flash_rp, cmd_ready}, 32'b011);
    end
    run_op(model(1'b0, 22'h000040, 16'h5555, 8'h00, 8'h80, 1), 1'b0);

    // Randomized operations against the reference model.
    for (int k = 0; k < 12; k++) begin
      logic [7:0] bs, fs;
      bs = 8'($urandom) & 8'h7F;
      fs = ($urandom_range(0, 1) == 0) ? (8'h80 | (8'($urandom) & 8'h45)) : (8'h80 | 8'($urandom));
      rv = model(1'($urandom), 22'($urandom), 16'($urandom), bs, fs, $urandom_range(0, 10));
      run_op(rv, 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "bench timeout");
  end

endmodule

// File: doc/flash_writer.md
Name: flash_writer

Overview:
- Write-side counterpart to the boot-time flash reader.
- Programs single 16-bit words and erases blocks in the on-board CFI/Intel-command-set parallel flash, so images sent over UART can be stored for the bootloader.
- Sits on raw_clk2 next to flash_ctrl. The two share the flash pins through an external mux selected by `busy`; that mux is not part of this block.

Parameters:
- WE_CYCLES, 2, clocks flash_we is held low per bus write.
- RD_CYCLES, 2, clocks flash_oe is held low before status is sampled.
- POLL_LIMIT, 1048576, maximum status polls before timeout.

Ports:
- clk  in  1  flash-domain clock (raw_clk2).
- rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  request strobe, accepted when cmd_ready=1.
- cmd_erase  in  1  1=block erase, 0=word program.
- cmd_addr  in  22  word address [22:1].
- cmd_data  in  16  program data (ignored for erase).
- cmd_ready  out  1  high only in IDLE.
- busy  out  1  high from acceptance until the done pulse.
- done  out  1  one-cycle completion pulse.
- error  out  1  valid with done; held until next acceptance.
- status_out  out  8  last status register read.
- flash_addr  out  23  {cmd_addr,1'b0}.
- flash_data  inout  16  driven only during write cycles, else hi-Z.
- flash_byte  out  1  constant 1 (word mode).
- flash_vpen  out  1  constant 1.
- flash_ce  out  1  active low.
- flash_oe  out  1  active low.
- flash_we  out  1  active low.
- flash_rp  out  1  registered ~rst.

Behaviour:
- Reset values: cmd_ready=1, busy=0, done=0, error=0, status_out=0, ce=oe=we=1, flash_data hi-Z, flash_rp=0 while rst is high and 1 one cycle after rst drops. FSM returns to IDLE.
- Bus write cycle, 1+WE_CYCLES+1 clocks:
  - Setup: address and data driven, ce=0, we=1.
  - WE_CYCLES clocks with we=0.
  - Hold: we=1, data still driven.
  - Then ce=1 and data released.
- Bus read cycle, 1+RD_CYCLES+1 clocks:
  - Setup: ce=0, oe=1, hi-Z.
  - RD_CYCLES clocks with oe=0; flash_data[7:0] sampled on the last oe-low edge.
  - Recovery: ce=1, oe=1.
- Acceptance: cmd_valid && cmd_ready latches cmd_* and clears error. While busy, cmd_valid is ignored and not queued.
- FSM: IDLE -> CMD -> ARG -> POLL -> (CLR) -> RESTORE -> DONE -> IDLE.
  - CMD: write 0x0040 (program) or 0x0020 (erase) at the address.
  - ARG: write cmd_data (program) or 0x00D0 (erase) at the address.
  - POLL: repeated status reads; each read updates status_out. Exit when SR[7]=1; stay otherwise.
  - Error = SR[5]|SR[4]|SR[3]|SR[1] at exit, or poll count reaching POLL_LIMIT. On error go to CLR: write 0x0050, error=1.
  - RESTORE: write 0x00FF (read-array) so flash_ctrl reads correctly.
  - DONE: done=1 for one cycle, busy drops the same cycle, then IDLE with cmd_ready=1.
- Poll counter: 21 bits, cleared on acceptance, saturating. On timeout status_out keeps the last value read.
- Latency, defaults, no error, N polls: 4+4+4N+4 clocks from acceptance to done.
- Simultaneous rst and cmd_valid: rst wins and nothing is accepted.
- rst mid-operation: pins are forced idle on the next edge and flash_rp pulses low, which aborts the device operation. No done pulse.

Decomposition:
- Shared package/include (define.v):
  - Flash command codes: FLASH_CMD_PROGRAM 16'h0040, FLASH_CMD_ERASE 16'h0020, FLASH_CMD_CONFIRM 16'h00D0, FLASH_CMD_CLRSR 16'h0050, FLASH_CMD_READ 16'h00FF.
  - Status bit indices.
  - FSM state encodings.
- Sub-module flash_bus_cycle: executes one read or write cycle with start/rd_wr/addr/wdata inputs, ack/rdata outputs, and owns all pin timing. flash_writer sequences it.

Test Plan:
- Program 0x000010 <- 0xBEEF, model returns SR 0x00 twice then 0x80.
  - Bus shows writes 0x0040@0x20, 0xBEEF@0x20, 3 reads, 0x00FF.
  - done at clock 24; error=0; status_out=0x80.
- Erase cmd_addr 0x010000, model ready after 5 polls: writes 0x0020, 0x00D0 at flash_addr 0x020000, then 5 reads, then 0x00FF; error=0.
- Program with model SR=0x90: writes 0x0050 then 0x00FF; done with error=1, status_out=0x90. The next accepted command clears error.
- Timeout, POLL_LIMIT=8 and SR stuck at 0x00: exactly 8 reads, then 0x0050, 0x00FF; error=1.
- cmd_valid pulsed while busy: ignored, exactly one operation on the bus. cmd_ready=0 until the cycle after done.
- rst asserted during POLL: next edge ce=oe=we=1, data hi-Z, flash_rp=0, no done pulse. After release, cmd_ready=1 and a new program completes normally.
